qp_mem_arbiter: RTL and testbench

- Owns the single port of the query-patch SRAM, which has a 1-cycle read latency.
- The port is shared between the Wishbone slave controller (host debug access) and two accelerator requesters: the query loader (write) and the patch fetcher (read).
- `wbs_mode` selects the owner. Ownership changes only after any in-flight read has drained.
- In core mode, writer and reader are round-robin arbitrated cycle by cycle.

---
 rtl/qp_mem_arbiter_if.sv | 61 ++++++
 rtl/qp_mem_arbiter.sv | 115 +++++++++++
 tb/tb_qp_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qp_mem_arbiter_if.sv
// Bundle of host, core-requester and SRAM signals around the query-patch memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface qp_mem_arbiter_if #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int ROW_SIZE   = 24,
  parameter int COL_SIZE   = 17,
  parameter int ADDRW      = $clog2(ROW_SIZE*COL_SIZE)
);
  localparam int PW = PATCH_SIZE*DATA_WIDTH;

  logic            wbs_mode;
  logic            wbs_qp_mem_csb0;
  logic            wbs_qp_mem_web0;
  logic [ADDRW-1:0] wbs_qp_mem_addr0;
  logic [PW-1:0]   wbs_qp_mem_wpatch0;
  logic [PW-1:0]   wbs_qp_mem_rpatch0;

  logic            wr_req;
  logic [ADDRW-1:0] wr_addr;
  logic [PW-1:0]   wr_patch;
  logic            wr_gnt;

  logic            rd_req;
  logic [ADDRW-1:0] rd_addr;
  logic            rd_gnt;
  logic            rd_valid;
  logic [PW-1:0]   rd_patch;

  logic            mem_csb0;
  logic            mem_web0;
  logic [ADDRW-1:0] mem_addr0;
  logic [PW-1:0]   mem_wpatch0;
  logic [PW-1:0]   mem_rpatch0;

  logic            busy;

  modport slave (
    input  wbs_mode, wbs_qp_mem_csb0, wbs_qp_mem_web0, wbs_qp_mem_addr0, wbs_qp_mem_wpatch0,
    output wbs_qp_mem_rpatch0,
    input  wr_req, wr_addr, wr_patch,
    output wr_gnt,
    input  rd_req, rd_addr,
    output rd_gnt, rd_valid, rd_patch,
    output mem_csb0, mem_web0, mem_addr0, mem_wpatch0,
    input  mem_rpatch0,
    output busy
  );

  modport master (
    output wbs_mode, wbs_qp_mem_csb0, wbs_qp_mem_web0, wbs_qp_mem_addr0, wbs_qp_mem_wpatch0,
    input  wbs_qp_mem_rpatch0,
    output wr_req, wr_addr, wr_patch,
    input  wr_gnt,
    output rd_req, rd_addr,
    input  rd_gnt, rd_valid, rd_patch,
    input  mem_csb0, mem_web0, mem_addr0, mem_wpatch0,
    output mem_rpatch0,
    input  busy
  );
endinterface

// File: rtl/qp_mem_arbiter.sv
// Owns the single query-patch SRAM port: host passthrough in host mode, round-robin
// between the query loader (write) and patch fetcher (read) in core mode.
module qp_mem_arbiter #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int ROW_SIZE   = 24,
  parameter int COL_SIZE   = 17,
  parameter int ADDRW      = $clog2(ROW_SIZE*COL_SIZE)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  qp_mem_arbiter_if.slave    bus
);
  localparam int PW = PATCH_SIZE*DATA_WIDTH;

  typedef enum logic [1:0] {
    CORE,
    DRAIN_TO_HOST,
    HOST,
    DRAIN_TO_CORE
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic             rd_valid_q;
  logic             busy_q;

  logic             wr_gnt_c;
  logic             rd_gnt_c;
  logic             csb_c;
  logic             web_c;
  logic [ADDRW-1:0] addr_c;
  logic [PW-1:0]    wpatch_c;

  // Grants and the SRAM command are decoded in the same cycle as the request.
  always_comb begin
    wr_gnt_c = 1'b0;
    rd_gnt_c = 1'b0;
    csb_c    = 1'b1;
    web_c    = 1'b1;
    addr_c   = '0;
    wpatch_c = '0;
    case (state)
      CORE: begin
        if (bus.wr_req && (!bus.rd_req || !rr_ptr)) begin
          wr_gnt_c = 1'b1;
          csb_c    = 1'b0;
          web_c    = 1'b0;
          addr_c   = bus.wr_addr;
          wpatch_c = bus.wr_patch;
        end else if (bus.rd_req) begin
          rd_gnt_c = 1'b1;
          csb_c    = 1'b0;
          addr_c   = bus.rd_addr;
        end
      end
      HOST: begin
        csb_c    = bus.wbs_qp_mem_csb0;
        web_c    = bus.wbs_qp_mem_web0;
        addr_c   = bus.wbs_qp_mem_addr0;
        wpatch_c = bus.wbs_qp_mem_wpatch0;
      end
      default: ;
    endcase
  end

  // Each drain state lasts one cycle, enough for a read granted just before the switch.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= CORE;
      rr_ptr     <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_gnt_c;
      if (wr_gnt_c)
        rr_ptr <= 1'b1;
      else if (rd_gnt_c)
        rr_ptr <= 1'b0;
      case (state)
        CORE: begin
          if (bus.wbs_mode) begin
            state  <= DRAIN_TO_HOST;
            busy_q <= 1'b1;
          end
        end
        DRAIN_TO_HOST, DRAIN_TO_CORE: begin
          busy_q <= 1'b0;
          state  <= bus.wbs_mode ? HOST : CORE;
        end
        HOST: begin
          if (!bus.wbs_mode) begin
            state  <= DRAIN_TO_CORE;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state  <= CORE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_gnt             = wr_gnt_c;
  assign bus.rd_gnt             = rd_gnt_c;
  assign bus.rd_valid           = rd_valid_q;
  assign bus.rd_patch           = bus.mem_rpatch0;
  assign bus.wbs_qp_mem_rpatch0 = bus.mem_rpatch0;
  assign bus.mem_csb0           = csb_c;
  assign bus.mem_web0           = web_c;
  assign bus.mem_addr0          = addr_c;
  assign bus.mem_wpatch0        = wpatch_c;
  assign bus.busy               = busy_q;
endmodule

// File: tb/tb_qp_mem_arbiter.sv
// Bench for qp_mem_arbiter: SRAM model plus a read-data scoreboard checked on rd_valid.
module tb_qp_mem_arbiter;
  localparam int DATA_WIDTH = 11;
  localparam int PATCH_SIZE = 5;
  localparam int ROW_SIZE   = 24;
  localparam int COL_SIZE   = 17;
  localparam int ADDRW      = $clog2(ROW_SIZE*COL_SIZE);
  localparam int PW         = PATCH_SIZE*DATA_WIDTH;
  localparam int DEPTH      = 1 << ADDRW;
  localparam logic [PW-1:0] BEEF = 55'h0_1010_DEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [PW-1:0] ref_mem [0:DEPTH-1];
  logic [PW-1:0] sram    [0:DEPTH-1];
  logic          sram_loaded = 1'b0;
  logic [PW-1:0] sram_q = '0;
  logic [PW-1:0] exp_q [$];

  qp_mem_arbiter_if #(.DATA_WIDTH(DATA_WIDTH), .PATCH_SIZE(PATCH_SIZE),
                      .ROW_SIZE(ROW_SIZE), .COL_SIZE(COL_SIZE), .ADDRW(ADDRW)) bus ();

  qp_mem_arbiter #(.DATA_WIDTH(DATA_WIDTH), .PATCH_SIZE(PATCH_SIZE),
                   .ROW_SIZE(ROW_SIZE), .COL_SIZE(COL_SIZE), .ADDRW(ADDRW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] init_val(input int i);
    if (i == 2) return BEEF;
    return PW'(i * 32'h9E37_79B1) ^ PW'(55'h2A_5A5A_0F0F_3C3C);
  endfunction

  function automatic logic [PW-1:0] rand_patch();
    return PW'({$urandom(), $urandom()});
  endfunction

  // SRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_val(i);
      sram_loaded <= 1'b1;
    end else if (!bus.mem_csb0) begin
      if (!bus.mem_web0) sram[bus.mem_addr0] <= bus.mem_wpatch0;
      else               sram_q <= sram[bus.mem_addr0];
    end
  end
  assign bus.mem_rpatch0 = sram_q;

  // Every rd_valid cycle must return the oldest outstanding expected read.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL rd_valid_unexpected got rd_valid=1 expected 0");
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (bus.rd_patch !== e) begin
          errors++;
          $display("[TB] FAIL rd_patch got %h expected %h", bus.rd_patch, e);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wbs_mode           = 1'b0;
    bus.wbs_qp_mem_csb0    = 1'b1;
    bus.wbs_qp_mem_web0    = 1'b1;
    bus.wbs_qp_mem_addr0   = '0;
    bus.wbs_qp_mem_wpatch0 = '0;
    bus.wr_req             = 1'b0;
    bus.wr_addr            = '0;
    bus.wr_patch           = '0;
    bus.rd_req             = 1'b0;
    bus.rd_addr            = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.rd_gnt, bus.mem_csb0, bus.mem_web0, bus.busy, bus.rd_valid,
         bus.mem_addr0, bus.mem_wpatch0} !== {6'b001100, {ADDRW{1'b0}}, {PW{1'b0}}}) begin
      errors++;
      $display("[TB] FAIL reset_outputs got gnt=%b%b csb=%b web=%b busy=%b vld=%b addr=%h wp=%h",
               bus.wr_gnt, bus.rd_gnt, bus.mem_csb0, bus.mem_web0, bus.busy, bus.rd_valid,
               bus.mem_addr0, bus.mem_wpatch0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.rd_gnt, bus.mem_csb0, bus.busy, bus.rd_valid} !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL core_idle got gnt=%b%b csb=%b busy=%b vld=%b expected 00 1 0 0",
               bus.wr_gnt, bus.rd_gnt, bus.mem_csb0, bus.busy, bus.rd_valid);
    end
    next_cycle();
  endtask

  task automatic test_write();
    bus.wr_req = 1'b1; bus.wr_addr = ADDRW'(5); bus.wr_patch = BEEF;
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.rd_gnt, bus.mem_csb0, bus.mem_web0} !== 4'b1000 ||
        bus.mem_addr0 !== ADDRW'(5) || bus.mem_wpatch0 !== BEEF) begin
      errors++;
      $display("[TB] FAIL write_grant got gnt=%b csb=%b web=%b addr=%0d wp=%h expected 1 0 0 5 %h",
               bus.wr_gnt, bus.mem_csb0, bus.mem_web0, bus.mem_addr0, bus.mem_wpatch0, BEEF);
    end
    ref_mem[5] = BEEF;
    next_cycle();
    bus.wr_req = 1'b0;
  endtask

  task automatic test_read();
    bus.rd_req = 1'b1; bus.rd_addr = ADDRW'(2);
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.rd_gnt, bus.mem_csb0, bus.mem_web0, bus.rd_valid} !== 5'b01010 ||
        bus.mem_addr0 !== ADDRW'(2)) begin
      errors++;
      $display("[TB] FAIL read_grant got gnt=%b%b csb=%b web=%b vld=%b addr=%0d expected 01 0 1 0 2",
               bus.wr_gnt, bus.rd_gnt, bus.mem_csb0, bus.mem_web0, bus.rd_valid, bus.mem_addr0);
    end
    exp_q.push_back(ref_mem[2]);
    next_cycle();
    bus.rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_valid_n1 got %b expected 1", bus.rd_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_valid_n2 got %b expected 0", bus.rd_valid);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic exp_w;
    do_reset();
    bus.wr_req = 1'b1; bus.wr_addr = ADDRW'(10); bus.wr_patch = rand_patch();
    bus.rd_req = 1'b1; bus.rd_addr = ADDRW'(20);
    for (int i = 0; i < 4; i++) begin
      exp_w = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if ({bus.wr_gnt, bus.rd_gnt} !== (exp_w ? 2'b10 : 2'b01) ||
          bus.mem_addr0 !== (exp_w ? bus.wr_addr : bus.rd_addr)) begin
        errors++;
        $display("[TB] FAIL round_robin_%0d got gnt=%b%b addr=%0d expected writer=%b",
                 i, bus.wr_gnt, bus.rd_gnt, bus.mem_addr0, exp_w);
      end
      if (exp_w) ref_mem[bus.wr_addr] = bus.wr_patch;
      else       exp_q.push_back(ref_mem[bus.rd_addr]);
      next_cycle();
      if (exp_w) begin
        bus.wr_addr = bus.wr_addr + ADDRW'(1);
        bus.wr_patch = rand_patch();
      end else begin
        bus.rd_addr = bus.rd_addr + ADDRW'(1);
      end
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_mode_switch();
    logic [PW-1:0] wp, hp;
    wp = rand_patch();
    hp = rand_patch();
    bus.rd_req = 1'b1; bus.rd_addr = ADDRW'(7); bus.wbs_mode = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.rd_gnt, bus.busy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL switch_read_grant got gnt=%b%b busy=%b expected 01 0",
               bus.wr_gnt, bus.rd_gnt, bus.busy);
    end
    exp_q.push_back(ref_mem[7]);
    next_cycle();
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = ADDRW'(9); bus.wr_patch = wp;
    bus.wbs_qp_mem_csb0 = 1'b0; bus.wbs_qp_mem_web0 = 1'b0;
    bus.wbs_qp_mem_addr0 = ADDRW'(4); bus.wbs_qp_mem_wpatch0 = hp;
    @(negedge clk);
    checks++;
    if ({bus.rd_valid, bus.wr_gnt, bus.rd_gnt, bus.mem_csb0, bus.busy} !== 5'b10011) begin
      errors++;
      $display("[TB] FAIL drain_to_host got vld=%b gnt=%b%b csb=%b busy=%b expected 1 00 1 1",
               bus.rd_valid, bus.wr_gnt, bus.rd_gnt, bus.mem_csb0, bus.busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.mem_csb0, bus.mem_web0, bus.busy} !== 4'b0000 ||
        bus.mem_addr0 !== ADDRW'(4) || bus.mem_wpatch0 !== hp) begin
      errors++;
      $display("[TB] FAIL host_write got gnt=%b csb=%b web=%b busy=%b addr=%0d wp=%h expected 0 0 0 0 4 %h",
               bus.wr_gnt, bus.mem_csb0, bus.mem_web0, bus.busy, bus.mem_addr0, bus.mem_wpatch0, hp);
    end
    ref_mem[4] = hp;
    next_cycle();
    bus.wbs_qp_mem_web0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mem_csb0, bus.mem_web0} !== 2'b01 || bus.mem_addr0 !== ADDRW'(4)) begin
      errors++;
      $display("[TB] FAIL host_read got csb=%b web=%b addr=%0d expected 0 1 4",
               bus.mem_csb0, bus.mem_web0, bus.mem_addr0);
    end
    next_cycle();
    bus.wbs_qp_mem_csb0 = 1'b1;
    bus.wbs_mode = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wbs_qp_mem_rpatch0 !== ref_mem[4] || {bus.mem_csb0, bus.wr_gnt} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL host_rdata got %h csb=%b gnt=%b expected %h 1 0",
               bus.wbs_qp_mem_rpatch0, bus.mem_csb0, bus.wr_gnt, ref_mem[4]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.busy, bus.mem_csb0} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL drain_to_core got gnt=%b busy=%b csb=%b expected 0 1 1",
               bus.wr_gnt, bus.busy, bus.mem_csb0);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.busy} !== 2'b10 || bus.mem_addr0 !== ADDRW'(9)) begin
      errors++;
      $display("[TB] FAIL back_in_core got gnt=%b busy=%b addr=%0d expected 1 0 9",
               bus.wr_gnt, bus.busy, bus.mem_addr0);
    end
    ref_mem[9] = wp;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_mode_pulse();
    logic [PW-1:0] wp;
    wp = rand_patch();
    bus.wbs_mode = 1'b1;
    bus.wbs_qp_mem_csb0 = 1'b0; bus.wbs_qp_mem_web0 = 1'b0;
    bus.wbs_qp_mem_addr0 = ADDRW'(3); bus.wbs_qp_mem_wpatch0 = rand_patch();
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.mem_csb0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL pulse_core_host_drop got busy=%b csb=%b expected 0 1", bus.busy, bus.mem_csb0);
    end
    next_cycle();
    bus.wbs_mode = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = ADDRW'(11); bus.wr_patch = wp;
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.busy, bus.mem_csb0} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL pulse_drain got gnt=%b busy=%b csb=%b expected 0 1 1",
               bus.wr_gnt, bus.busy, bus.mem_csb0);
    end
    next_cycle();
    bus.wbs_qp_mem_csb0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.busy, bus.mem_csb0} !== 3'b100 || bus.mem_addr0 !== ADDRW'(11)) begin
      errors++;
      $display("[TB] FAIL pulse_return got gnt=%b busy=%b csb=%b addr=%0d expected 1 0 0 11",
               bus.wr_gnt, bus.busy, bus.mem_csb0, bus.mem_addr0);
    end
    ref_mem[11] = wp;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [ADDRW-1:0] addrs [8];
    addrs = '{ADDRW'(5), ADDRW'(10), ADDRW'(11), ADDRW'(4), ADDRW'(3), ADDRW'(9), ADDRW'(21), ADDRW'(2)};
    bus.rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = addrs[i];
      @(negedge clk);
      checks++;
      if (bus.rd_gnt !== 1'b1 || bus.mem_addr0 !== addrs[i] || bus.mem_web0 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_read_%0d got gnt=%b addr=%0d web=%b expected 1 %0d 1",
                 i, bus.rd_gnt, bus.mem_addr0, bus.mem_web0, addrs[i]);
      end
      exp_q.push_back(ref_mem[addrs[i]]);
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_reset_mid_read();
    bus.rd_req = 1'b1; bus.rd_addr = ADDRW'(2); bus.wbs_mode = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rd_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_read_grant got %b expected 1", bus.rd_gnt);
    end
    next_cycle();
    bus.rd_req = 1'b0;
    #1;
    checks++;
    if ({bus.rd_valid, bus.busy} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL rst_pre got vld=%b busy=%b expected 1 1", bus.rd_valid, bus.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rd_valid, bus.busy, bus.wr_gnt, bus.rd_gnt, bus.mem_csb0} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL rst_async got vld=%b busy=%b gnt=%b%b csb=%b expected 0 0 00 1",
               bus.rd_valid, bus.busy, bus.wr_gnt, bus.rd_gnt, bus.mem_csb0);
    end
    bus.wbs_mode = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = ADDRW'(12); bus.wr_patch = rand_patch();
    @(negedge clk);
    checks++;
    if ({bus.wr_gnt, bus.busy, bus.rd_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL rst_core_after got gnt=%b busy=%b vld=%b expected 1 0 0",
               bus.wr_gnt, bus.busy, bus.rd_valid);
    end
    ref_mem[12] = bus.wr_patch;
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    idle_inputs();
    do_reset();
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_mode_switch();
    test_mode_pulse();
    test_back_to_back();
    test_reset_mid_read();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL reads_outstanding got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end
endmodule
